us_tx_engine: RTL
=================

# us_tx_engine

Upstream transmit stage: consumes the 64-bit entries that the inbound FSM pushes into the upstream command FIFO and serialises each one into a PCIe TLP on the 32-bit TRN transmit interface of the Spartan-6 endpoint. Three entry types are handled: completion without data (CPL), completion with one DW of data (CPLD), and posted 32-bit memory write (WR32) carrying a DMA payload. On WR32 completion it returns `up_wr_cmd_compl`/`cmd_id` to the inbound FSM so that FSM can clear its per-channel busy bit.

## Interface
- No parameters; type encodings are the `US_CMD_CPL_TYPE`, `US_CMD_CPLD_TYPE`, `US_CMD_WR32_TYPE` and `US_CMD_INVALID` macros from param.v.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- us_cmd_fifo_empty_i  in  1  FIFO empty. The FIFO is first-word-fall-through.
- us_cmd_fifo_dout_i  in  64  head entry, valid while not empty.
- us_cmd_fifo_rd_en_o  out  1  pop strobe, one cycle per entry.
- completer_id_i  in  16  {bus, device, function} of this endpoint.
- rd_addr_o  out  11  register read address for CPLD payload.
- rd_data_i  in  32  combinational read data for `rd_addr_o`.
- trn_td_o  out  32  TX data.
- trn_tsof_n_o  out  1  start of frame, active low.
- trn_teof_n_o  out  1  end of frame, active low.
- trn_tsrc_rdy_n_o  out  1  source ready, active low.
- trn_tsrc_dsc_n_o  out  1  source discontinue; held at 1.
- trn_tdst_rdy_n_i  in  1  destination ready, active low.
- up_wr_cmd_compl_o  out  1  one-cycle pulse when a WR32 TLP has been fully sent.
- cmd_id_o  out  2  channel ID of the completed WR32; valid with the pulse.
- busy_o  out  1  high in every state except IDLE.

## Operation
- **Entry layout:** [63:62] type, [61:57] len, [56:55] cmd_id.
  - CPL/CPLD: [54:52] tc, [51] td, [50] ep, [49:48] attr, [47:38] req_len, [37:22] rid, [21:14] tag, [13:6] be, [5:0] DW address.
  - WR32: [31:0] host address.
- **States:** IDLE, HDR0, HDR1, HDR2, DATA.
- **IDLE:** when the FIFO is not empty, latch the entry, pulse rd_en and go to HDR0. An entry of type INVALID is popped and dropped, and the block stays in IDLE.
- **Beat acceptance:** each of HDR0/HDR1/HDR2/DATA drives one beat with tsrc_rdy_n=0. The state advances only when trn_tdst_rdy_n_i=0.
- **After HDR2:** CPL returns to IDLE, with teof on HDR2. CPLD and WR32 go to DATA.
- **DATA:** CPLD sends one beat, `rd_data_i`, with teof. WR32 sends N beats of the payload pattern, with teof on the last.
- **WR32 length:** N = 2^(len−2) DW. len<2 gives N=1; len>7 gives N=32.
- **WR32 payload:** a 32-bit pattern register, reset to 0, incremented after every accepted WR32 data beat. It persists across TLPs.
- **rd_addr_o** = {3'b0, entry[5:0], 2'b00}, held from latch until IDLE.
- **Completion DW0:** {1'b0, fmt (2'b10 for CPLD, 2'b00 for CPL), 5'b01010, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, length}, with length 1 for CPLD and 0 for CPL.
- **Completion DW1:** {completer_id, 3'b000, 1'b0, byte_count[11:0]}.
  - byte_count is taken from be[3:0] = entry[9:6]: 1xx1→4; 01x1 or 1x10→3; 0011, 0110 or 1100→2; anything else→1.
  - CPL always uses byte_count 4.
- **Completion DW2:** {rid, tag, 1'b0, lower_addr}.
  - lower_addr = {entry[4:0], lo}.
  - lo from be[3:0]: xxx1→00, xx10→01, x100→10, 1000→11, 0000→00.
- **WR32 DW0:** {1'b0, 2'b10, 5'b00000, 1'b0, 3'b0, 4'b0, 2'b0, 2'b0, 2'b0, N[9:0]}.
- **WR32 DW1:** {completer_id, 8'd0, lastBE, 4'hF}; lastBE = 4'h0 when N=1, otherwise 4'hF.
- **WR32 DW2:** {addr[31:2], 2'b00}.
- **WR32 completion:** up_wr_cmd_compl_o pulses, together with cmd_id_o = the latched cmd_id, in the cycle after the last data beat is accepted.

## Timing
- **Reset values:** state IDLE, rd_en 0, tsof_n/teof_n/tsrc_rdy_n/tsrc_dsc_n 1, td 0, compl 0, cmd_id 0, busy 0, rd_addr 0, pattern 0.
- **FIFO non-empty to first beat:** rd_en is high in the same cycle (IDLE), and HDR0 is driven on the TRN bus from the next cycle.
- **Back-to-back:** exactly one idle cycle between consecutive TLPs (the IDLE cycle).
- **Throttling:** while tdst_rdy_n=1, td, tsof and teof are held stable and tsrc_rdy_n stays 0. tsrc_rdy_n is never deasserted mid-packet.
- **Reset mid-packet:** all outputs return to their reset values immediately; the partial TLP is abandoned and no eof is sent.
- **FIFO empty:** rd_en is never asserted while empty.

## Test plan
- **CPLD:** be=4'hF, addr=6'h01, rid=16'h0100, tag=8'h05, rd_data=32'hDEADBEEF, completer_id=16'h0200, dst always ready.
  - Beats: 32'h4A000001, 32'h02000004, 32'h01000504, 32'hDEADBEEF.
  - sof on beat 1, eof on beat 4.
- **CPL:** be=4'h1, otherwise as above.
  - Beats: 32'h0A000000, 32'h02000004, DW2, with eof on the third beat.
- **WR32:** len=6, addr=32'h1000_0040, cmd_id=1.
  - 19 beats: DW0 32'h40000010, then DW1, then DW2 32'h10000040, then payload 0..15.
  - compl pulse with cmd_id_o=1 one cycle after the last beat.
  - A second WR32 starts its payload at 16.
- **Backpressure:** tdst_rdy_n toggled 1/0 every cycle during a WR32 with len=2 → all beats are delivered unchanged, each held while not ready.
- **Boundary:** one INVALID entry followed by one CPL → INVALID popped with no TRN activity, then the CPL is sent normally.
- **Reset mid-packet:** rst_n asserted during HDR1 → tsrc_rdy_n=1 asynchronously and busy=0; after release, a new entry is sent from HDR0.

Source files
------------

// File: rtl/us_tx_engine.sv
// Upstream TX engine: pops 64-bit upstream commands and serialises them as
// CPL / CPLD / MWr32 TLPs onto the 32-bit TRN transmit interface.
`timescale 1ns/1ps
module us_tx_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        us_cmd_fifo_empty_i,
  input  logic [63:0] us_cmd_fifo_dout_i,
  output logic        us_cmd_fifo_rd_en_o,
  input  logic [15:0] completer_id_i,
  output logic [10:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic [31:0] trn_td_o,
  output logic        trn_tsof_n_o,
  output logic        trn_teof_n_o,
  output logic        trn_tsrc_rdy_n_o,
  output logic        trn_tsrc_dsc_n_o,
  input  logic        trn_tdst_rdy_n_i,
  output logic        up_wr_cmd_compl_o,
  output logic [1:0]  cmd_id_o,
  output logic        busy_o
);

  localparam logic [1:0] US_CMD_CPL_TYPE  = 2'b00;
  localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b01;
  localparam logic [1:0] US_CMD_WR32_TYPE = 2'b10;
  localparam logic [1:0] US_CMD_INVALID   = 2'b11;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;

  state_t      state, state_nxt;
  logic [63:0] entry;
  logic [5:0]  beat_cnt;
  logic [31:0] pattern;
  logic        compl_q;
  logic [1:0]  cmd_id_q;
  logic        rd_en_c;

  // req_len is carried in the entry but the TLP builders never need it.
  logic unused_req_len;
  assign unused_req_len = ^us_cmd_fifo_dout_i[47:38];

  function automatic logic [5:0] wr_dw_count(input logic [4:0] len);
    if (len < 5'd2)      return 6'd1;
    else if (len > 5'd7) return 6'd32;
    else                 return 6'd1 << (len - 5'd2);
  endfunction

  function automatic logic [11:0] byte_count(input logic [3:0] be);
    casez (be)
      4'b1??1:                    return 12'd4;
      4'b01?1, 4'b1?10:           return 12'd3;
      4'b0011, 4'b0110, 4'b1100:  return 12'd2;
      default:                    return 12'd1;
    endcase
  endfunction

  function automatic logic [1:0] lower_lo(input logic [3:0] be);
    casez (be)
      4'b???1: return 2'b00;
      4'b??10: return 2'b01;
      4'b?100: return 2'b10;
      4'b1000: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0]  typ;
  logic        is_cpl, is_cpld, is_wr;
  logic [5:0]  n_dw;
  logic        last_beat;
  logic        accept;
  logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;
  logic [31:0] wr_dw0, wr_dw1, wr_dw2;

  assign typ       = entry[63:62];
  assign is_cpl    = (typ == US_CMD_CPL_TYPE);
  assign is_cpld   = (typ == US_CMD_CPLD_TYPE);
  assign is_wr     = (typ == US_CMD_WR32_TYPE);
  assign n_dw      = wr_dw_count(entry[61:57]);
  assign last_beat = (beat_cnt == n_dw - 6'd1);
  assign accept    = ~trn_tdst_rdy_n_i;

  assign cpl_dw0 = {1'b0, (is_cpld ? 2'b10 : 2'b00), 5'b01010, 1'b0, entry[54:52],
                    4'b0, entry[51], entry[50], entry[49:48], 2'b0,
                    (is_cpld ? 10'd1 : 10'd0)};
  assign cpl_dw1 = {completer_id_i, 3'b000, 1'b0,
                    (is_cpld ? byte_count(entry[9:6]) : 12'd4)};
  assign cpl_dw2 = {entry[37:22], entry[21:14], 1'b0, entry[4:0], lower_lo(entry[9:6])};

  assign wr_dw0 = {1'b0, 2'b10, 5'b00000, 1'b0, 3'b0, 4'b0, 2'b0, 2'b0, 2'b0, {4'b0, n_dw}};
  assign wr_dw1 = {completer_id_i, 8'd0, ((n_dw == 6'd1) ? 4'h0 : 4'hF), 4'hF};
  assign wr_dw2 = {entry[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      entry    <= '0;
      beat_cnt <= '0;
      pattern  <= '0;
      compl_q  <= 1'b0;
      cmd_id_q <= '0;
    end else begin
      state   <= state_nxt;
      compl_q <= 1'b0;
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (!us_cmd_fifo_empty_i && us_cmd_fifo_dout_i[63:62] != US_CMD_INVALID)
          entry <= us_cmd_fifo_dout_i;
      end
      if (state == DATA && accept && !is_cpld) begin
        pattern  <= pattern + 32'd1;
        beat_cnt <= beat_cnt + 6'd1;
        if (last_beat) begin
          compl_q  <= 1'b1;
          cmd_id_q <= entry[56:55];
        end
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    rd_en_c          = 1'b0;
    trn_td_o         = 32'd0;
    trn_tsof_n_o     = 1'b1;
    trn_teof_n_o     = 1'b1;
    trn_tsrc_rdy_n_o = 1'b1;
    case (state)
      IDLE: begin
        if (!us_cmd_fifo_empty_i) begin
          rd_en_c = 1'b1;
          if (us_cmd_fifo_dout_i[63:62] != US_CMD_INVALID) state_nxt = HDR0;
        end
      end
      HDR0: begin
        trn_tsrc_rdy_n_o = 1'b0;
        trn_tsof_n_o     = 1'b0;
        trn_td_o         = is_wr ? wr_dw0 : cpl_dw0;
        if (accept) state_nxt = HDR1;
      end
      HDR1: begin
        trn_tsrc_rdy_n_o = 1'b0;
        trn_td_o         = is_wr ? wr_dw1 : cpl_dw1;
        if (accept) state_nxt = HDR2;
      end
      HDR2: begin
        trn_tsrc_rdy_n_o = 1'b0;
        trn_td_o         = is_wr ? wr_dw2 : cpl_dw2;
        trn_teof_n_o     = ~is_cpl;
        if (accept) state_nxt = is_cpl ? IDLE : DATA;
      end
      DATA: begin
        trn_tsrc_rdy_n_o = 1'b0;
        if (is_cpld) begin
          trn_td_o     = rd_data_i;
          trn_teof_n_o = 1'b0;
          if (accept) state_nxt = IDLE;
        end else begin
          trn_td_o     = pattern;
          trn_teof_n_o = ~last_beat;
          if (accept && last_beat) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the pop so a non-empty FIFO is never drained while in reset.
  assign us_cmd_fifo_rd_en_o = rd_en_c & rst_n;
  assign rd_addr_o           = {3'b0, entry[5:0], 2'b00};
  assign trn_tsrc_dsc_n_o    = 1'b1;
  assign up_wr_cmd_compl_o   = compl_q;
  assign cmd_id_o            = cmd_id_q;
  assign busy_o              = (state != IDLE);

endmodule
